// File: rtl/cons_heap_pkg.sv
// Shared types and constants for the cons-cell heap: FSM states, NIL and
// the car/cdr word selectors.
package cons_heap_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD       = 3'd1,
    CONS_CAR = 3'd2,
    CONS_CDR = 3'd3,
    SET      = 3'd4,
    DONE     = 3'd5
  } state_t;

  localparam int   NIL     = 0;
  localparam logic SEL_CAR = 1'b0;
  localparam logic SEL_CDR = 1'b1;

endpackage

// File: rtl/cons_heap_if.sv
// Request/response bundle of the cons heap. Requests are single-cycle levels
// sampled only while the heap is idle; completions are one-cycle pulses.
interface cons_heap_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
) ();

  logic              req;
  logic [ADDR_W-1:0] addr_in;
  logic              data_ready;
  logic [DATA_W-1:0] data_out;

  logic              cons_en;
  logic [DATA_W-1:0] cons_car;
  logic [DATA_W-1:0] cons_cdr;
  logic              cons_done;
  logic [ADDR_W-1:0] cons_ptr;
  logic              cons_err;

  logic              set_en;
  logic              set_sel;
  logic [ADDR_W-1:0] set_ptr;
  logic [DATA_W-1:0] set_data;
  logic              set_done;

  logic              busy;
  logic              heap_full;

  modport master (
    output req, addr_in, cons_en, cons_car, cons_cdr,
           set_en, set_sel, set_ptr, set_data,
    input  data_ready, data_out, cons_done, cons_ptr, cons_err,
           set_done, busy, heap_full
  );

  modport slave (
    input  req, addr_in, cons_en, cons_car, cons_cdr,
           set_en, set_sel, set_ptr, set_data,
    output data_ready, data_out, cons_done, cons_ptr, cons_err,
           set_done, busy, heap_full
  );

endinterface

// File: rtl/heap_ram.sv
// Single-port word RAM: synchronous write, synchronous read-first output.
module heap_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/cons_heap.sv
// Bump-allocated cons-cell heap with read, allocate (cons) and mutate (set)
// operations, one at a time, on a single-port RAM.
module cons_heap
  import cons_heap_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 12,
  parameter int HEAP_BASE  = 2,
  parameter int HEAP_WORDS = 4094
) (
  input  logic        clk,
  input  logic        reset,
  cons_heap_if.slave  bus,
  output state_t      dbg_state
);

  localparam int              AW1      = ADDR_W + 1;
  localparam logic [ADDR_W:0] HEAP_END = AW1'(HEAP_BASE + HEAP_WORDS);

  state_t            state;
  logic [ADDR_W-1:0] free_ptr;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] car_q;
  logic [DATA_W-1:0] cdr_q;
  logic              rd_wait;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  // Extra headroom bit so a heap ending exactly at 2**ADDR_W compares correctly.
  assign bus.heap_full = ({1'b0, free_ptr} + AW1'(2)) > HEAP_END;
  assign bus.busy      = (state != IDLE);
  assign dbg_state     = state;

  // car_q doubles as the set payload; op_addr holds the read or set target.
  always_comb begin
    ram_addr  = op_addr;
    ram_we    = 1'b0;
    ram_wdata = car_q;
    case (state)
      CONS_CAR: begin
        ram_addr = free_ptr;
        ram_we   = !bus.heap_full;
      end
      CONS_CDR: begin
        ram_addr  = free_ptr + ADDR_W'(1);
        ram_we    = 1'b1;
        ram_wdata = cdr_q;
      end
      SET:     ram_we = 1'b1;
      default: ;
    endcase
  end

  heap_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .we    (ram_we),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      free_ptr       <= ADDR_W'(HEAP_BASE);
      op_addr        <= '0;
      car_q          <= '0;
      cdr_q          <= '0;
      rd_wait        <= 1'b0;
      bus.data_ready <= 1'b0;
      bus.data_out   <= '0;
      bus.cons_done  <= 1'b0;
      bus.cons_ptr   <= '0;
      bus.cons_err   <= 1'b0;
      bus.set_done   <= 1'b0;
    end else begin
      bus.data_ready <= 1'b0;
      bus.cons_done  <= 1'b0;
      bus.cons_err   <= 1'b0;
      bus.set_done   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cons_en) begin
            car_q <= bus.cons_car;
            cdr_q <= bus.cons_cdr;
            state <= CONS_CAR;
          end else if (bus.set_en) begin
            op_addr <= bus.set_ptr + (bus.set_sel == SEL_CDR ? ADDR_W'(1) : ADDR_W'(0));
            car_q   <= bus.set_data;
            state   <= SET;
          end else if (bus.req) begin
            op_addr <= bus.addr_in;
            rd_wait <= 1'b0;
            state   <= RD;
          end
        end
        // First RD cycle lets the RAM register the word; the second forwards it.
        RD: begin
          if (!rd_wait) begin
            rd_wait <= 1'b1;
          end else begin
            bus.data_out   <= ram_rdata;
            bus.data_ready <= 1'b1;
            state          <= DONE;
          end
        end
        CONS_CAR: begin
          if (bus.heap_full) begin
            bus.cons_err <= 1'b1;
            bus.cons_ptr <= ADDR_W'(NIL);
            state        <= DONE;
          end else begin
            state <= CONS_CDR;
          end
        end
        CONS_CDR: begin
          bus.cons_ptr  <= free_ptr;
          bus.cons_done <= 1'b1;
          free_ptr      <= free_ptr + ADDR_W'(2);
          state         <= DONE;
        end
        SET: begin
          bus.set_done <= 1'b1;
          state        <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cons_heap.sv
// Bench for cons_heap: a default-size heap and a 4-word heap share one set of
// stimulus lines, steered by sel_small, against a behavioural heap model.
module tb_cons_heap;
  import cons_heap_pkg::*;

  localparam int DW = 16;
  localparam int AW = 12;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Handshake: a request is a level held across one rising edge while the DUT
  // is idle; completion is a one-cycle done/err/ready pulse, busy is high
  // from acceptance until the cycle after that pulse.
  logic          sel_small;
  logic          req, cons_en, set_en, set_sel;
  logic [AW-1:0] addr_in, set_ptr;
  logic [DW-1:0] cons_car, cons_cdr, set_data;

  cons_heap_if #(.DATA_W(DW), .ADDR_W(AW)) m_if ();
  cons_heap_if #(.DATA_W(DW), .ADDR_W(AW)) s_if ();
  state_t m_state, s_state;

  cons_heap #(.DATA_W(DW), .ADDR_W(AW), .HEAP_BASE(2), .HEAP_WORDS(4094)) u_dut (
    .clk(clk), .reset(reset), .bus(m_if.slave), .dbg_state(m_state));
  cons_heap #(.DATA_W(DW), .ADDR_W(AW), .HEAP_BASE(2), .HEAP_WORDS(4)) u_small (
    .clk(clk), .reset(reset), .bus(s_if.slave), .dbg_state(s_state));

  assign m_if.req = req & !sel_small;         assign s_if.req = req & sel_small;
  assign m_if.cons_en = cons_en & !sel_small; assign s_if.cons_en = cons_en & sel_small;
  assign m_if.set_en = set_en & !sel_small;   assign s_if.set_en = set_en & sel_small;
  assign m_if.addr_in = addr_in;   assign s_if.addr_in = addr_in;
  assign m_if.cons_car = cons_car; assign s_if.cons_car = cons_car;
  assign m_if.cons_cdr = cons_cdr; assign s_if.cons_cdr = cons_cdr;
  assign m_if.set_sel = set_sel;   assign s_if.set_sel = set_sel;
  assign m_if.set_ptr = set_ptr;   assign s_if.set_ptr = set_ptr;
  assign m_if.set_data = set_data; assign s_if.set_data = set_data;

  logic          o_data_ready, o_cons_done, o_cons_err, o_set_done, o_busy, o_heap_full;
  logic [DW-1:0] o_data_out;
  logic [AW-1:0] o_cons_ptr;
  assign o_data_ready = sel_small ? s_if.data_ready : m_if.data_ready;
  assign o_data_out   = sel_small ? s_if.data_out   : m_if.data_out;
  assign o_cons_done  = sel_small ? s_if.cons_done  : m_if.cons_done;
  assign o_cons_ptr   = sel_small ? s_if.cons_ptr   : m_if.cons_ptr;
  assign o_cons_err   = sel_small ? s_if.cons_err   : m_if.cons_err;
  assign o_set_done   = sel_small ? s_if.set_done   : m_if.set_done;
  assign o_busy       = sel_small ? s_if.busy       : m_if.busy;
  assign o_heap_full  = sel_small ? s_if.heap_full  : m_if.heap_full;

  // ---------------- scoreboard / reference model ----------------
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] model_mem [2][4096];
  int            model_free [2];
  int            model_end  [2];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void model_cons(input logic [DW-1:0] car, input logic [DW-1:0] cdr,
                                     output logic err, output logic [AW-1:0] ptr);
    int d = sel_small ? 1 : 0;
    if (model_free[d] + 2 > model_end[d]) begin
      err = 1'b1;
      ptr = '0;
    end else begin
      err = 1'b0;
      ptr = AW'(model_free[d]);
      model_mem[d][model_free[d] % 4096]       = car;
      model_mem[d][(model_free[d] + 1) % 4096] = cdr;
      model_free[d] += 2;
    end
  endfunction

  function automatic void model_set(input logic [AW-1:0] p, input logic sel, input logic [DW-1:0] d);
    model_mem[sel_small ? 1 : 0][(int'(p) + int'(sel)) % 4096] = d;
  endfunction

  function automatic void model_reset();
    model_free[0] = 2; model_end[0] = 4096;
    model_free[1] = 2; model_end[1] = 6;
  endfunction

  // ---------------- driver tasks ----------------
  // Called at the negedge right after the accepting edge; lat counts cycles
  // from there until a completion pulse (-1 if none within budget).
  task automatic wait_pulse(output int lat);
    lat = 0;
    while (!(o_cons_done || o_cons_err || o_set_done || o_data_ready) && lat < 16) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 16) lat = -1;
  endtask

  task automatic do_cons(input logic [DW-1:0] car, input logic [DW-1:0] cdr, output int lat,
                         output logic done, output logic err, output logic [AW-1:0] ptr);
    @(negedge clk);
    cons_en = 1'b1; cons_car = car; cons_cdr = cdr;
    @(negedge clk);
    cons_en = 1'b0; cons_car = DW'($urandom); cons_cdr = DW'($urandom);
    wait_pulse(lat);
    done = o_cons_done; err = o_cons_err; ptr = o_cons_ptr;
  endtask

  task automatic do_set(input logic [AW-1:0] p, input logic sel, input logic [DW-1:0] d,
                        output int lat, output logic done);
    @(negedge clk);
    set_en = 1'b1; set_ptr = p; set_sel = sel; set_data = d;
    @(negedge clk);
    set_en = 1'b0; set_ptr = AW'($urandom); set_data = DW'($urandom);
    wait_pulse(lat);
    done = o_set_done;
  endtask

  task automatic do_read(input logic [AW-1:0] a, output int lat, output logic rdy, output logic [DW-1:0] d);
    @(negedge clk);
    req = 1'b1; addr_in = a;
    @(negedge clk);
    req = 1'b0; addr_in = AW'($urandom);
    wait_pulse(lat);
    rdy = o_data_ready; d = o_data_out;
  endtask

  task automatic run_cons(input string name, input logic [DW-1:0] car, input logic [DW-1:0] cdr);
    int lat; logic done, err, e_err; logic [AW-1:0] ptr, e_ptr;
    model_cons(car, cdr, e_err, e_ptr);
    do_cons(car, cdr, lat, done, err, ptr);
    check({name, " cons_ptr"}, 32'(ptr), 32'(e_ptr));
    check({name, " cons_err"}, 32'(err), 32'(e_err));
    check({name, " cons_done"}, 32'(done), 32'(!e_err));
    check({name, " latency"}, 32'(lat), e_err ? 32'd1 : 32'd2);
  endtask

  task automatic run_set(input string name, input logic [AW-1:0] p, input logic sel, input logic [DW-1:0] d);
    int lat; logic done;
    model_set(p, sel, d);
    do_set(p, sel, d, lat, done);
    check({name, " set_done"}, 32'(done), 32'd1);
    check({name, " latency"}, 32'(lat), 32'd1);
  endtask

  task automatic run_read(input string name, input logic [AW-1:0] a);
    int lat; logic rdy; logic [DW-1:0] d;
    exp_q.push_back(model_mem[sel_small ? 1 : 0][a]);
    do_read(a, lat, rdy, d);
    check({name, " data_out"}, 32'(d), 32'(exp_q.pop_front()));
    check({name, " data_ready"}, 32'(rdy), 32'd1);
    check({name, " latency"}, 32'(lat), 32'd2);
  endtask

  // ---------------- directed vector table ----------------
  typedef enum int {OP_CONS, OP_SET, OP_READ} op_e;
  typedef struct {
    op_e           op;
    logic [AW-1:0] addr;
    logic          sel;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    logic [DW-1:0] exp_val;
    int            exp_lat;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, seen, free0;
    logic done, err, rdy, e_err;
    logic [AW-1:0] ptr, e_ptr, a;
    logic [DW-1:0] d, car, cdr;
    vec_t v;

    vecs[0]  = '{OP_CONS, 12'h000, 1'b0, 16'hDEAD, 16'hBEEF, 16'h0002, 2};
    vecs[1]  = '{OP_CONS, 12'h000, 1'b0, 16'h1234, 16'h5678, 16'h0004, 2};
    vecs[2]  = '{OP_CONS, 12'h000, 1'b0, 16'hABCD, 16'hEF01, 16'h0006, 2};
    vecs[3]  = '{OP_READ, 12'h003, 1'b0, 16'h0000, 16'h0000, 16'hBEEF, 2};
    vecs[4]  = '{OP_SET,  12'h004, 1'b0, 16'hCAFE, 16'h0000, 16'h0000, 1};
    vecs[5]  = '{OP_READ, 12'h004, 1'b0, 16'h0000, 16'h0000, 16'hCAFE, 2};
    vecs[6]  = '{OP_READ, 12'h005, 1'b0, 16'h0000, 16'h0000, 16'h5678, 2};
    vecs[7]  = '{OP_READ, 12'h002, 1'b0, 16'h0000, 16'h0000, 16'hDEAD, 2};
    vecs[8]  = '{OP_SET,  12'h006, 1'b1, 16'h1111, 16'h0000, 16'h0000, 1};
    vecs[9]  = '{OP_READ, 12'h007, 1'b0, 16'h0000, 16'h0000, 16'h1111, 2};
    vecs[10] = '{OP_READ, 12'h006, 1'b0, 16'h0000, 16'h0000, 16'hABCD, 2};

    // ---- clock/reset ----
    sel_small = 1'b0; req = 1'b0; cons_en = 1'b0; set_en = 1'b0; set_sel = 1'b0;
    addr_in = '0; set_ptr = '0; cons_car = '0; cons_cdr = '0; set_data = '0;
    reset = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset state", 32'(m_state), 32'(IDLE));
    check("reset busy", 32'(m_if.busy), 32'd0);
    check("reset pulses", 32'({m_if.data_ready, m_if.cons_done, m_if.cons_err, m_if.set_done}), 32'd0);
    check("reset cons_ptr", 32'(m_if.cons_ptr), 32'd0);
    check("reset data_out", 32'(m_if.data_out), 32'd0);
    check("reset heap_full", 32'(m_if.heap_full), 32'd0);
    check("reset small heap_full", 32'(s_if.heap_full), 32'd0);

    // ---- table-driven directed vectors ----
    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      case (v.op)
        OP_CONS: begin
          model_cons(v.d0, v.d1, e_err, e_ptr);
          do_cons(v.d0, v.d1, lat, done, err, ptr);
          check($sformatf("vec%0d cons_ptr", i), 32'(ptr), 32'(v.exp_val));
          check($sformatf("vec%0d cons_done", i), 32'(done), 32'd1);
        end
        OP_SET: begin
          model_set(v.addr, v.sel, v.d0);
          do_set(v.addr, v.sel, v.d0, lat, done);
          check($sformatf("vec%0d set_done", i), 32'(done), 32'd1);
        end
        default: begin
          do_read(v.addr, lat, rdy, d);
          check($sformatf("vec%0d data_out", i), 32'(d), 32'(v.exp_val));
        end
      endcase
      check($sformatf("vec%0d latency", i), 32'(lat), 32'(v.exp_lat));
    end

    // ---- randomized ops against the model ----
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0: run_cons($sformatf("rnd%0d", i), DW'($urandom), DW'($urandom));
        1: run_set($sformatf("rnd%0d", i), AW'(2 + 2 * $urandom_range(0, (model_free[0] - 4) / 2)),
                   1'($urandom_range(0, 1)), DW'($urandom));
        default: run_read($sformatf("rnd%0d", i), AW'($urandom_range(2, model_free[0] - 1)));
      endcase
    end

    // ---- cons_en and req in the same idle cycle ----
    car = DW'($urandom); cdr = DW'($urandom);
    model_cons(car, cdr, e_err, e_ptr);
    @(negedge clk);
    cons_en = 1'b1; req = 1'b1; addr_in = 12'h002; cons_car = car; cons_cdr = cdr;
    @(negedge clk);
    cons_en = 1'b0; req = 1'b0;
    wait_pulse(lat);
    check("prio cons latency", 32'(lat), 32'd2);
    check("prio cons_ptr", 32'(o_cons_ptr), 32'(e_ptr));
    seen = 0;
    repeat (5) begin
      if (o_data_ready) seen++;
      @(negedge clk);
    end
    check("prio dropped read", 32'(seen), 32'd0);

    // ---- set_en and req in the same idle cycle ----
    a = AW'(model_free[0] - 2);
    d = DW'($urandom);
    model_set(a, SEL_CDR, d);
    @(negedge clk);
    set_en = 1'b1; req = 1'b1; addr_in = 12'h002; set_ptr = a; set_sel = SEL_CDR; set_data = d;
    @(negedge clk);
    set_en = 1'b0; req = 1'b0;
    wait_pulse(lat);
    check("prio set latency", 32'(lat), 32'd1);
    check("prio set_done", 32'(o_set_done), 32'd1);
    seen = 0;
    repeat (5) begin
      if (o_data_ready) seen++;
      @(negedge clk);
    end
    check("prio set dropped read", 32'(seen), 32'd0);
    run_read("prio set readback", a + AW'(1));

    // ---- cons_en held through the whole operation ----
    car = DW'($urandom); cdr = DW'($urandom);
    model_cons(car, cdr, e_err, e_ptr);
    @(negedge clk);
    cons_en = 1'b1; cons_car = car; cons_cdr = cdr;
    @(negedge clk);
    check("held busy", 32'(o_busy), 32'd1);
    wait_pulse(lat);
    check("held latency", 32'(lat), 32'd2);
    check("held cons_ptr", 32'(o_cons_ptr), 32'(e_ptr));
    cons_en = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (o_cons_done) seen++;
    end
    check("held no second cons", 32'(seen), 32'd0);
    run_cons("after held", DW'($urandom), DW'($urandom));

    // ---- reset while in CONS_CDR ----
    free0 = model_free[0];
    @(negedge clk);
    cons_en = 1'b1; cons_car = 16'h0BAD; cons_cdr = 16'hF00D;
    @(negedge clk);
    cons_en = 1'b0;
    check("abort in CONS_CAR", 32'(m_state), 32'(CONS_CAR));
    @(negedge clk);
    check("abort in CONS_CDR", 32'(m_state), 32'(CONS_CDR));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_mem[0][free0] = 16'h0BAD;
    model_reset();
    check("abort no cons_done", 32'(o_cons_done), 32'd0);
    check("abort state", 32'(m_state), 32'(IDLE));
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (o_cons_done || o_cons_err) seen++;
    end
    check("abort no late pulse", 32'(seen), 32'd0);
    run_cons("post abort", 16'h4242, 16'h2424);
    run_read("post abort car", 12'h002);

    // ---- 4-word heap: fill, refuse, no write ----
    sel_small = 1'b1;
    run_cons("small 1", 16'hAAAA, 16'hBBBB);
    check("small not full", 32'(o_heap_full), 32'd0);
    run_cons("small 2", 16'hCCCC, 16'hDDDD);
    check("small full", 32'(o_heap_full), 32'd1);
    run_set("small guard", 12'h006, SEL_CAR, 16'h7777);
    run_cons("small 3", 16'h9999, 16'h8888);
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (o_cons_done) seen++;
    end
    check("small no done after err", 32'(seen), 32'd0);
    check("small still full", 32'(o_heap_full), 32'd1);
    run_read("small guard word", 12'h006);
    run_read("small cell2 car", 12'h004);
    run_read("small cell1 cdr", 12'h003);
    sel_small = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
